// File: rtl/sya_tile_sched.sv
// Tile scheduler for the systolic array: it accepts one config, feeds K joint act/wgt beats,
// drains the skewed pipeline with zero injection, streams NUM_ROW result rows, then pulses done.
module sya_tile_sched #(
  parameter int NUM_ROW = 16,
  parameter int NUM_COL = 16,
  parameter int KW      = 16,
  localparam int DRAIN_LEN = NUM_ROW + NUM_COL - 1,
  localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cfgVld,
  output logic          o_cfgRdy,
  input  logic [KW-1:0] i_cfgK,
  input  logic          i_inActVld,
  output logic          o_inActRdy,
  input  logic          i_inWgtVld,
  output logic          o_inWgtRdy,
  output logic          o_shiftEn,
  output logic          o_injZero,
  output logic          o_accClr,
  output logic          o_outVld,
  input  logic          i_outRdy,
  output logic [RW-1:0] o_outRowIdx,
  output logic          o_busy,
  output logic          o_done
);

  localparam int DW = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, OUT, DONE} state_t;

  state_t        r_state, w_next;
  logic [KW-1:0] r_k, r_beatCnt;
  logic [DW-1:0] r_drainCnt;
  logic [RW-1:0] r_rowCnt;

  logic w_fire, w_lastBeat, w_lastDrain, w_lastRow;

  assign w_fire      = (r_state == FEED) && i_inActVld && i_inWgtVld;
  assign w_lastBeat  = (r_beatCnt == r_k - KW'(1));
  assign w_lastDrain = (r_drainCnt == DW'(DRAIN_LEN - 1));
  assign w_lastRow   = (r_rowCnt == RW'(NUM_ROW - 1));

  always_comb begin
    w_next      = r_state;
    o_cfgRdy    = 1'b0;
    o_inActRdy  = 1'b0;
    o_inWgtRdy  = 1'b0;
    o_shiftEn   = 1'b0;
    o_injZero   = 1'b0;
    o_accClr    = 1'b0;
    o_outVld    = 1'b0;
    o_outRowIdx = '0;
    o_busy      = (r_state != IDLE);
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        o_cfgRdy = 1'b1;
        if (i_cfgVld) w_next = (i_cfgK == '0) ? DONE : FEED;
      end
      FEED: begin
        o_inActRdy = w_fire;
        o_inWgtRdy = w_fire;
        o_shiftEn  = w_fire;
        o_accClr   = w_fire && (r_beatCnt == '0);
        if (w_fire && w_lastBeat) w_next = DRAIN;
      end
      DRAIN: begin
        o_shiftEn = 1'b1;
        o_injZero = 1'b1;
        if (w_lastDrain) w_next = OUT;
      end
      OUT: begin
        o_outVld    = 1'b1;
        o_outRowIdx = r_rowCnt;
        if (i_outRdy && w_lastRow) w_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Each counter is cleared on the transition into the state that uses it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_beatCnt  <= '0;
      r_drainCnt <= '0;
      r_rowCnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (i_cfgVld) begin
          r_k       <= i_cfgK;
          r_beatCnt <= '0;
        end
        FEED: if (w_fire) begin
          r_beatCnt <= r_beatCnt + KW'(1);
          if (w_lastBeat) r_drainCnt <= '0;
        end
        DRAIN: begin
          r_drainCnt <= r_drainCnt + DW'(1);
          if (w_lastDrain) r_rowCnt <= '0;
        end
        OUT: if (i_outRdy) r_rowCnt <= r_rowCnt + RW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sya_tile_sched.sv
// Directed bench for sya_tile_sched with NUM_ROW=NUM_COL=4 (DRAIN_LEN=7); expected
// per-cycle outputs are written out from the tile timeline relative to config acceptance.
module tb_sya_tile_sched;

  logic        clk = 1'b0;
  logic        rst, cfgVld, actVld, wgtVld, outRdy;
  logic [15:0] cfgK;
  logic        cfgRdy, actRdy, wgtRdy, shiftEn, injZero, accClr, outVld, busy, done;
  logic [1:0]  rowIdx;

  int nTests = 0;
  int nFail  = 0;
  int nHs;

  sya_tile_sched #(.NUM_ROW(4), .NUM_COL(4), .KW(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfgVld(cfgVld), .o_cfgRdy(cfgRdy), .i_cfgK(cfgK),
    .i_inActVld(actVld), .o_inActRdy(actRdy), .i_inWgtVld(wgtVld), .o_inWgtRdy(wgtRdy),
    .o_shiftEn(shiftEn), .o_injZero(injZero), .o_accClr(accClr), .o_outVld(outVld),
    .i_outRdy(outRdy), .o_outRowIdx(rowIdx), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int eCfgRdy, input int eActRdy,
                          input int eShift, input int eInj, input int eClr, input int eOutVld,
                          input int eRow, input int eBusy, input int eDone);
    checkOutput({tag, " cfgRdy"},  int'(cfgRdy),  eCfgRdy);
    checkOutput({tag, " actRdy"},  int'(actRdy),  eActRdy);
    checkOutput({tag, " wgtRdy"},  int'(wgtRdy),  eActRdy);
    checkOutput({tag, " shiftEn"}, int'(shiftEn), eShift);
    checkOutput({tag, " injZero"}, int'(injZero), eInj);
    checkOutput({tag, " accClr"},  int'(accClr),  eClr);
    checkOutput({tag, " outVld"},  int'(outVld),  eOutVld);
    checkOutput({tag, " rowIdx"},  int'(rowIdx),  eRow);
    checkOutput({tag, " busy"},    int'(busy),    eBusy);
    checkOutput({tag, " done"},    int'(done),    eDone);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input int k, input logic av, input logic wv,
                               input logic ordy);
    cfgVld = v;
    cfgK   = 16'(k);
    actVld = av;
    wgtVld = wv;
    outRdy = ordy;
    #1;
  endtask

  // Full tile with every valid/ready held high; t=0 is the config-accept cycle.
  task automatic runTile(input string name, input int k);
    for (int t = 0; t <= k + 13; t++) begin
      bit feed, drn, outp;
      feed = (t >= 1) && (t <= k);
      drn  = (t >= k + 1) && (t <= k + 7);
      outp = (t >= k + 8) && (t <= k + 11);
      applyStimulus(t == 0, k, 1'b1, 1'b1, 1'b1);
      checkAll($sformatf("%s t%0d", name, t), int'(t == 0 || t == k + 13), int'(feed),
               int'(feed || drn), int'(drn), int'(t == 1), int'(outp), outp ? t - k - 8 : 0,
               int'(t >= 1 && t <= k + 12), int'(t == k + 12));
      nextCycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    checkAll("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    runTile("basic", 3);

    // Joint-handshake stall: weights absent t1..t3.
    for (int t = 0; t <= 18; t++) begin
      bit feed, drn, outp;
      feed = (t >= 4) && (t <= 5);
      drn  = (t >= 6) && (t <= 12);
      outp = (t >= 13) && (t <= 16);
      applyStimulus(t == 0, 2, 1'b1, !(t >= 1 && t <= 3), 1'b1);
      checkAll($sformatf("stall t%0d", t), int'(t == 0 || t == 18), int'(feed),
               int'(feed || drn), int'(drn), int'(t == 4), int'(outp), outp ? t - 13 : 0,
               int'(t >= 1 && t <= 17), int'(t == 17));
      nextCycle();
    end

    // Output backpressure at row 1, plus a config pulse during OUT that must be ignored.
    nHs = 0;
    for (int t = 0; t <= 16; t++) begin
      bit stallOut;
      int eRow;
      stallOut = (t >= 10) && (t <= 12);
      eRow = (t <= 9) ? 0 : (t <= 13) ? 1 : (t == 14) ? 2 : 3;
      applyStimulus(t == 0 || t == 11, (t == 11) ? 5 : 1, 1'b1, 1'b1, !stallOut);
      if (t >= 9 && t <= 15) begin
        checkOutput($sformatf("bp t%0d outVld", t), int'(outVld), 1);
        checkOutput($sformatf("bp t%0d rowIdx", t), int'(rowIdx), eRow);
        checkOutput($sformatf("bp t%0d cfgRdy", t), int'(cfgRdy), 0);
        if (outVld && outRdy) nHs++;
      end
      if (t == 16) checkOutput("bp done", int'(done), 1);
      nextCycle();
    end
    checkOutput("bp handshakes", nHs, 4);
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);
      checkAll($sformatf("ignored cfg idle%0d", t), 1, 0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
    end

    // K=0: straight to DONE.
    applyStimulus(1'b1, 0, 1'b1, 1'b1, 1'b1);
    checkAll("k0 t0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);
    checkAll("k0 t1", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nextCycle();
    checkAll("k0 t2", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during DRAIN abandons the tile.
    for (int t = 0; t <= 4; t++) begin
      applyStimulus(t == 0, 2, 1'b1, 1'b1, 1'b1);
      nextCycle();
    end
    checkOutput("rst pre injZero", int'(injZero), 1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);
      checkAll($sformatf("rst post%0d", t), 1, 0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
    end
    runTile("afterRst", 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/sya_tile_sched.md
Name: sya_tile_sched

Overview:
Tile-level scheduler for the systolic array (SYA) datapath. It accepts one tile configuration, feeds CfgK joint activation/weight beats into the skewed pipeline registers, then drains the array with zero injection. It then streams NUM_ROW result rows out over a valid/ready port and pulses Done. It sits between the global controller and the PE array/CPM register chain and drives all array shift/clear enables.

Parameters:
NUM_ROW, 16, PE array rows; also the number of output beats per tile
NUM_COL, 16, PE array columns
KW, 16, width of the accumulation-length field CfgK
DRAIN_LEN, NUM_ROW+NUM_COL-1, drain cycles after the last feed beat (derived; not overridden)

Ports:
Clk  in  1  clock; all logic on the rising edge
Rst  in  1  synchronous reset, active-high
CfgVld  in  1  tile config valid
CfgRdy  out  1  scheduler ready for a config
CfgK  in  KW  accumulation length (feed beats) for the tile
InActVld  in  1  activation beat valid
InActRdy  out  1  activation beat consumed
InWgtVld  in  1  weight beat valid
InWgtRdy  out  1  weight beat consumed
ShiftEn  out  1  advance all array pipeline registers this cycle
InjZero  out  1  array edge inputs forced to zero this cycle
AccClr  out  1  PE accumulators load instead of accumulate; accompanies the first feed beat
OutVld  out  1  result row available
OutRdy  in  1  downstream accepts result row
OutRowIdx  out  clog2(NUM_ROW)  row index of the current output beat
Busy  out  1  state != IDLE
Done  out  1  one-cycle pulse at tile completion

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high (Rst), sampled only on the rising edge of Clk.
- States: IDLE, FEED, DRAIN, OUT, DONE. State and all counters are registered. Every output is a combinational decode of the registered state, counters and inputs.
- Reset: while Rst is high at an edge, the next state is IDLE and the beat, drain and row counters plus the latched K are cleared. After that edge: CfgRdy=1; InActRdy, InWgtRdy, ShiftEn, InjZero, AccClr, OutVld, Busy, Done all 0; OutRowIdx=0.
- Reset mid-operation abandons the tile: no Done pulse and no further output beats.
- IDLE: CfgRdy=1. On CfgVld&CfgRdy, CfgK is latched.
  - K>0 goes to FEED.
  - K=0 goes directly to DONE, with no feed, drain or output beats.
- FEED:
  - Fire = InActVld & InWgtVld. The two inputs are a joint handshake.
  - InActRdy = InWgtRdy = ShiftEn = Fire. Neither Rdy is asserted without the other.
  - AccClr = Fire & (beat count == 0).
  - Beat count increments on Fire. On the Fire where beat count == K-1, go to DRAIN.
  - No Fire means a stall: no shift, state and counters hold.
- DRAIN: ShiftEn=1 and InjZero=1 every cycle for exactly DRAIN_LEN cycles. No input handshakes. Then go to OUT.
- OUT:
  - OutVld=1 and OutRowIdx = row count.
  - Row count increments on OutVld&OutRdy. The handshake at row NUM_ROW-1 goes to DONE.
  - OutRdy=0 holds OutVld and OutRowIdx stable.
  - ShiftEn=0.
- DONE: Done=1 for one cycle, then IDLE. CfgRdy=0 in DONE; a config is accepted on the following cycle at the earliest.
- Busy=1 in FEED, DRAIN, OUT and DONE.
- Counters: beat count is KW bits; row count is clog2(NUM_ROW) bits; drain count is wide enough for DRAIN_LEN. All counters clear on entry to FEED, DRAIN and OUT respectively. K=2^KW-1 must work without wrap.
- CfgVld outside IDLE is ignored and not queued.
- Latency, with Vld/Rdy held high: config accepted at cycle t0.
  - FEED: t1..tK.
  - DRAIN: tK+1..tK+DRAIN_LEN.
  - OUT: next NUM_ROW cycles.
  - Done: the cycle after the last OUT beat.
  - CfgRdy: the cycle after Done.

Test Plan:
- Parameters for all scenarios: NUM_ROW=4, NUM_COL=4, DRAIN_LEN=7.
- Basic tile: CfgK=3, all Vld/Rdy held high, config at t0.
  - ShiftEn high t1..t10; AccClr only at t1; InjZero t4..t10.
  - OutVld t11..t14 with OutRowIdx 0,1,2,3; Done at t15; CfgRdy back at t16.
- Joint-handshake stall: CfgK=2, InActVld=1, InWgtVld low t1..t3, then high.
  - InActRdy=InWgtRdy=ShiftEn=0 t1..t3; first Fire and AccClr at t4; DRAIN begins t6.
- Output backpressure: OutRdy=0 for 3 cycles at row 1.
  - OutVld stays 1 and OutRowIdx stays 1 throughout.
  - Exactly 4 handshakes occur in total; Done is one cycle after the row-3 handshake.
- CfgK=0: config at t0 -> Done=1 at t1, no ShiftEn, OutVld=0 throughout, CfgRdy=1 at t2.
- Reset mid-tile: assert Rst for 1 cycle during DRAIN.
  - Next cycle: IDLE with CfgRdy=1, all other outputs 0, no Done.
  - A new CfgK=1 tile then completes normally: AccClr with its single feed beat.
- Ignored config: CfgVld pulsed during OUT -> no effect; after Done the scheduler returns to IDLE and awaits a fresh CfgVld.
